// File: rtl/adder_digit_serial_if.sv
// ============================================================================
// Module   : adder_digit_serial_if
// Brief    : Start/busy/done handshake and operand/result bus for the
//            digit-serial adder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface adder_digit_serial_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] s;
  logic             cout;
  logic             ovf;

  modport master (
    output start, a, b, cin, sub,
    input  busy, done, s, cout, ovf
  );

  modport slave (
    input  start, a, b, cin, sub,
    output busy, done, s, cout, ovf
  );
endinterface

`default_nettype wire

// File: rtl/adder_digit_serial.sv
// ============================================================================
// Module   : adder_digit_serial
// Brief    : Multi-cycle adder/subtractor processing DIGIT bits per clock,
//            WIDTH/DIGIT cycles per operation. Overflow flag is built only
//            when ADDER_DIGIT_SERIAL_OVF_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module adder_digit_serial #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  wire logic              clk,
  input  wire logic              rst,
  adder_digit_serial_if.slave    bus
);

  localparam int c_N  = WIDTH / DIGIT;
  localparam int c_CW = (c_N > 1) ? $clog2(c_N) : 1;
  localparam logic [c_CW-1:0] c_LAST = c_CW'(c_N - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic [c_CW-1:0]  cnt_q, cnt_d;

  logic [DIGIT:0]   w_dsum;
  logic [WIDTH-1:0] w_a_shr;
  logic [WIDTH-1:0] w_b_shr;
  logic [WIDTH-1:0] w_result;
  logic             w_run_last;

  assign w_dsum = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]}
                + {{DIGIT{1'b0}}, carry_q};

  assign w_run_last = (state_q == ST_RUN) && (cnt_q == c_LAST);

  // Only the upper WIDTH-DIGIT bits of the result shift register are kept:
  // the incoming digit is combined with them to form the full result.
  if (DIGIT == WIDTH) begin : g_single
    assign w_a_shr  = '0;
    assign w_b_shr  = '0;
    assign w_result = w_dsum[DIGIT-1:0];
  end else begin : g_multi
    logic [WIDTH-DIGIT-1:0] res_q;

    assign w_a_shr  = {{DIGIT{1'b0}}, a_q[WIDTH-1:DIGIT]};
    assign w_b_shr  = {{DIGIT{1'b0}}, b_q[WIDTH-1:DIGIT]};
    assign w_result = {w_dsum[DIGIT-1:0], res_q};

    always_ff @(posedge clk) begin
      if (rst) begin
        res_q <= '0;
      end else if (state_q == ST_RUN) begin
        res_q <= w_result[WIDTH-1:DIGIT];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    s_d     = s_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.start) begin
          // Subtraction is a + ~b + 1; the forced carry replaces cin.
          a_d     = bus.a;
          b_d     = bus.sub ? ~bus.b : bus.b;
          carry_d = bus.sub ? 1'b1 : bus.cin;
          cnt_d   = '0;
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        a_d     = w_a_shr;
        b_d     = w_b_shr;
        carry_d = w_dsum[DIGIT];
        cnt_d   = cnt_q + c_CW'(1);
        if (w_run_last) begin
          s_d     = w_result;
          cout_d  = w_dsum[DIGIT];
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign bus.busy = (state_q == ST_RUN);
  assign bus.done = (state_q == ST_DONE);
  assign bus.s    = s_q;
  assign bus.cout = cout_q;

`ifdef ADDER_DIGIT_SERIAL_OVF_EN
  logic ovf_q;
  logic w_msb_cin;

  // Carry into the top bit recovered from the top bit's sum and operands.
  assign w_msb_cin = w_dsum[DIGIT-1] ^ a_q[DIGIT-1] ^ b_q[DIGIT-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (w_run_last) begin
      ovf_q <= w_msb_cin ^ w_dsum[DIGIT];
    end
  end

  assign bus.ovf = ovf_q;
`else
  assign bus.ovf = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_adder_digit_serial.sv
// ============================================================================
// Module   : tb_adder_digit_serial
// Brief    : Self-checking bench for adder_digit_serial (WIDTH=16, DIGIT=4).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_adder_digit_serial;

  localparam int WIDTH = 16;
  localparam int DIGIT = 4;
  localparam int N     = WIDTH / DIGIT;
`ifdef ADDER_DIGIT_SERIAL_OVF_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic [WIDTH-1:0] s;
    logic             cout;
    logic             ovf;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  adder_digit_serial_if #(.WIDTH(WIDTH)) bus ();

  adder_digit_serial #(
    .WIDTH(WIDTH),
    .DIGIT(DIGIT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Reference: whole-word arithmetic, signed range check for overflow.
  function automatic void model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                input logic cin, input logic sub,
                                output logic [WIDTH-1:0] s, output logic cout,
                                output logic ovf);
    logic [WIDTH:0] u;
    longint sa, sb, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (sub) begin
      u    = {1'b0, a} - {1'b0, b};
      cout = (a >= b);
      r    = sa - sb;
    end else begin
      u    = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
      cout = u[WIDTH];
      r    = sa + sb + longint'(cin);
    end
    s   = u[WIDTH-1:0];
    ovf = OVF_EN && ((r > (2**(WIDTH-1)) - 1) || (r < -(2**(WIDTH-1))));
  endfunction

  // Launches one operation at the current negedge; returns at the negedge
  // of the done cycle with the edge count from acceptance to done.
  task automatic do_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic cin, input logic sub,
                       output int lat, output int busy_cnt);
    bus.a = a; bus.b = b; bus.cin = cin; bus.sub = sub; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.a = WIDTH'($urandom); bus.b = WIDTH'($urandom);
    bus.cin = 1'($urandom);   bus.sub = 1'($urandom);
    lat = 0;
    busy_cnt = 0;
    while (bus.done !== 1'b1 && lat < 20) begin
      if (bus.busy === 1'b1) busy_cnt++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    int lat, bc;
    bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0; bus.sub = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    n_cmp++;
    if ({bus.busy, bus.done, bus.cout, bus.ovf} !== 4'b0000) begin
      n_err++;
      $display("FAIL reset_flags: got busy/done/cout/ovf=%b expected 0000",
               {bus.busy, bus.done, bus.cout, bus.ovf});
    end
    n_cmp++;
    if (bus.s !== 16'h0000) begin
      n_err++;
      $display("FAIL reset_s: got %h expected 0000", bus.s);
    end
    do_op(16'h0000, 16'h0000, 1'b0, 1'b0, lat, bc);
    n_cmp++;
    if (lat !== N || bc !== N) begin
      n_err++;
      $display("FAIL zero_latency: got lat=%0d busy=%0d expected %0d/%0d", lat, bc, N, N);
    end
    n_cmp++;
    if ({bus.s, bus.cout, bus.ovf, bus.busy} !== {16'h0000, 3'b000}) begin
      n_err++;
      $display("FAIL zero_result: got s=%h cout=%b ovf=%b busy=%b expected 0000 0 0 0",
               bus.s, bus.cout, bus.ovf, bus.busy);
    end
  endtask

  task automatic test_carry();
    vec_t v[3];
    int lat, bc;
    v[0] = '{16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0};
    v[1] = '{16'h0008, 16'h0008, 1'b0, 1'b0, 16'h0010, 1'b0, 1'b0};
    v[2] = '{16'h0800, 16'h0800, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0};
    for (int i = 0; i < 3; i++) begin
      do_op(v[i].a, v[i].b, v[i].cin, v[i].sub, lat, bc);
      n_cmp++;
      if ({bus.s, bus.cout, bus.ovf} !== {v[i].s, v[i].cout, v[i].ovf & OVF_EN} || lat !== N) begin
        n_err++;
        $display("FAIL carry[%0d]: got s=%h cout=%b ovf=%b lat=%0d expected %h %b %b %0d",
                 i, bus.s, bus.cout, bus.ovf, lat, v[i].s, v[i].cout, v[i].ovf & OVF_EN, N);
      end
    end
  endtask

  task automatic test_ovf();
    vec_t v[3];
    int lat, bc;
    v[0] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
    v[1] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
    v[2] = '{16'h0000, 16'h8000, 1'b0, 1'b1, 16'h8000, 1'b0, 1'b1};
    for (int i = 0; i < 3; i++) begin
      do_op(v[i].a, v[i].b, v[i].cin, v[i].sub, lat, bc);
      n_cmp++;
      if ({bus.s, bus.cout, bus.ovf} !== {v[i].s, v[i].cout, v[i].ovf & OVF_EN}) begin
        n_err++;
        $display("FAIL ovf[%0d]: got s=%h cout=%b ovf=%b expected %h %b %b",
                 i, bus.s, bus.cout, bus.ovf, v[i].s, v[i].cout, v[i].ovf & OVF_EN);
      end
    end
  endtask

  task automatic test_sub();
    vec_t v[3];
    int lat, bc;
    v[0] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    v[1] = '{16'h0007, 16'h0005, 1'b1, 1'b1, 16'h0002, 1'b1, 1'b0};
    v[2] = '{16'h1234, 16'h1234, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0};
    for (int i = 0; i < 3; i++) begin
      do_op(v[i].a, v[i].b, v[i].cin, v[i].sub, lat, bc);
      n_cmp++;
      if ({bus.s, bus.cout, bus.ovf} !== {v[i].s, v[i].cout, v[i].ovf & OVF_EN}) begin
        n_err++;
        $display("FAIL sub[%0d]: got s=%h cout=%b ovf=%b expected %h %b %b",
                 i, bus.s, bus.cout, bus.ovf, v[i].s, v[i].cout, v[i].ovf & OVF_EN);
      end
    end
  endtask

  task automatic test_ignore_start();
    int lat;
    @(negedge clk);
    bus.a = 16'h0123; bus.b = 16'h0456; bus.cin = 1'b0; bus.sub = 1'b0; bus.start = 1'b1;
    @(negedge clk);
    // Spurious request sampled while RUN is in progress.
    bus.a = 16'hFFFF; bus.b = 16'hFFFF; bus.cin = 1'b1; bus.start = 1'b1;
    lat = 0;
    while (bus.done !== 1'b1 && lat < 20) begin
      @(negedge clk);
      bus.start = 1'b0;
      lat++;
    end
    n_cmp++;
    if ({bus.s, bus.cout} !== {16'h0579, 1'b0} || lat !== N) begin
      n_err++;
      $display("FAIL ignore_start: got s=%h cout=%b lat=%0d expected 0579 0 %0d",
               bus.s, bus.cout, lat, N);
    end
    @(negedge clk);
    n_cmp++;
    if ({bus.busy, bus.done} !== 2'b00) begin
      n_err++;
      $display("FAIL ignore_start_idle: got busy/done=%b expected 00", {bus.busy, bus.done});
    end
  endtask

  task automatic test_mid_reset();
    int lat, bc;
    bus.a = 16'h1111; bus.b = 16'h2222; bus.cin = 1'b0; bus.sub = 1'b0; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_cmp++;
    if ({bus.busy, bus.done, bus.s, bus.cout, bus.ovf} !== {2'b00, 16'h0000, 2'b00}) begin
      n_err++;
      $display("FAIL mid_reset: got busy=%b done=%b s=%h cout=%b ovf=%b expected all 0",
               bus.busy, bus.done, bus.s, bus.cout, bus.ovf);
    end
    repeat (N + 1) @(negedge clk);
    n_cmp++;
    if ({bus.busy, bus.done, bus.s} !== {2'b00, 16'h0000}) begin
      n_err++;
      $display("FAIL mid_reset_idle: got busy=%b done=%b s=%h expected 0 0 0000",
               bus.busy, bus.done, bus.s);
    end
    do_op(16'h0001, 16'h0002, 1'b0, 1'b0, lat, bc);
    n_cmp++;
    if (bus.s !== 16'h0003 || lat !== N) begin
      n_err++;
      $display("FAIL mid_reset_recover: got s=%h lat=%0d expected 0003 %0d", bus.s, lat, N);
    end
  endtask

  task automatic test_back_to_back();
    int lat, bc, gap;
    bit held;
    @(negedge clk);
    do_op(16'h0080, 16'h0080, 1'b0, 1'b0, lat, bc);
    n_cmp++;
    if (bus.s !== 16'h0100) begin
      n_err++;
      $display("FAIL b2b_first: got s=%h expected 0100", bus.s);
    end
    bus.a = 16'h1234; bus.b = 16'h1111; bus.cin = 1'b0; bus.sub = 1'b0; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    gap = 1;
    held = 1'b1;
    while (bus.done !== 1'b1 && gap < 20) begin
      if (bus.s !== 16'h0100 || bus.busy !== 1'b1) held = 1'b0;
      @(negedge clk);
      gap++;
    end
    n_cmp++;
    if (held !== 1'b1) begin
      n_err++;
      $display("FAIL b2b_hold: got s not held at 0100 with busy during second RUN, expected held");
    end
    n_cmp++;
    if (gap !== N + 1) begin
      n_err++;
      $display("FAIL b2b_gap: got %0d cycles between done pulses expected %0d", gap, N + 1);
    end
    n_cmp++;
    if (bus.s !== 16'h2345) begin
      n_err++;
      $display("FAIL b2b_second: got s=%h expected 2345", bus.s);
    end
  endtask

  task automatic test_random();
    logic [WIDTH-1:0] a, b, es;
    logic cin, sub, ec, eo;
    int lat, bc;
    for (int i = 0; i < 40; i++) begin
      a = WIDTH'($urandom); b = WIDTH'($urandom);
      cin = 1'($urandom);   sub = 1'($urandom);
      if (i % 5 == 0) begin a = 16'hFFFF; b = (sub) ? 16'hFFFF : 16'h0001; end
      repeat ($urandom_range(0, 2)) @(negedge clk);
      model(a, b, cin, sub, es, ec, eo);
      do_op(a, b, cin, sub, lat, bc);
      n_cmp++;
      if ({bus.s, bus.cout, bus.ovf} !== {es, ec, eo} || lat !== N || bc !== N) begin
        n_err++;
        $display("FAIL random[%0d] a=%h b=%h cin=%b sub=%b: got s=%h cout=%b ovf=%b lat=%0d expected %h %b %b %0d",
                 i, a, b, cin, sub, bus.s, bus.cout, bus.ovf, lat, es, ec, eo, N);
      end
    end
  endtask

  initial begin
    test_reset();
    test_carry();
    test_ovf();
    test_sub();
    test_ignore_start();
    test_mid_reset();
    test_back_to_back();
    test_random();
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

`default_nettype wire
